// File: rtl/ws2812b_pixel_rx.sv
`default_nettype none
// ws2812b_pixel_rx: receive-side model of one WS2812B pixel. Decodes the NRZ stream, latches
// the first 24 bits of each frame as GRB colour and forwards every later bit on dout.
module ws2812b_pixel_rx #(
  parameter int BIT_THRESH   = 60,
  parameter int MAX_HIGH     = 120,
  parameter int RESET_CYCLES = 5000,
  parameter int CNT_W        = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic        dout,
  output logic [23:0] grb,
  output logic        valid,
  output logic        err,
  output logic [4:0]  bit_cnt
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    READY = 2'd1,
    HIGH  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] GAP_CNT    = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] GAP_CNT_M1 = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LIMIT = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(BIT_THRESH);
  localparam logic [4:0]       FRAME_BITS = 5'd24;

  state_e           state_q;
  logic             sync1_q;
  logic             din_s_q;
  logic             din_prev_q;
  logic [CNT_W-1:0] low_cnt_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [4:0]       bit_cnt_q;
  logic [23:0]      shift_q;
  logic [23:0]      grb_q;
  logic             fwd_en_q;
  logic             dout_q;
  logic             valid_q;
  logic             err_q;

  logic             rise;
  logic             fall;
  logic             bit_d;
  logic [CNT_W-1:0] low_cnt_d;
  logic [CNT_W-1:0] high_cnt_d;

  assign rise       = din_s_q & ~din_prev_q;
  assign fall       = ~din_s_q & din_prev_q;
  assign bit_d      = (high_cnt_q > THRESH);
  assign low_cnt_d  = low_cnt_q + CNT_W'(1);
  assign high_cnt_d = high_cnt_q + CNT_W'(1);

  // The gap event is taken while the counter moves onto RESET_CYCLES, so it always lands on a
  // low cycle and saturation guarantees it fires only once per low period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      sync1_q    <= 1'b0;
      din_s_q    <= 1'b0;
      din_prev_q <= 1'b0;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      grb_q      <= '0;
      fwd_en_q   <= 1'b0;
      dout_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= din;
      din_s_q    <= sync1_q;
      din_prev_q <= din_s_q;
      dout_q     <= din_s_q & fwd_en_q;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        SYNC: begin
          if (din_s_q) begin
            low_cnt_q <= '0;
          end else if (low_cnt_q == GAP_CNT_M1) begin
            low_cnt_q <= GAP_CNT;
            bit_cnt_q <= '0;
            fwd_en_q  <= 1'b0;
            state_q   <= READY;
          end else begin
            low_cnt_q <= low_cnt_d;
          end
        end

        READY: begin
          if (rise) begin
            high_cnt_q <= CNT_W'(1);
            low_cnt_q  <= '0;
            state_q    <= HIGH;
          end else if (!din_s_q && low_cnt_q == GAP_CNT_M1) begin
            low_cnt_q <= GAP_CNT;
            bit_cnt_q <= '0;
            fwd_en_q  <= 1'b0;
            if (bit_cnt_q == FRAME_BITS) begin
              grb_q   <= shift_q;
              valid_q <= 1'b1;
            end else if (bit_cnt_q != 5'd0) begin
              err_q <= 1'b1;
            end
          end else if (!din_s_q && low_cnt_q != GAP_CNT) begin
            low_cnt_q <= low_cnt_d;
          end
        end

        HIGH: begin
          if (fall) begin
            low_cnt_q <= CNT_W'(1);
            state_q   <= READY;
            if (bit_cnt_q != FRAME_BITS) begin
              shift_q   <= {shift_q[22:0], bit_d};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == FRAME_BITS - 5'd1) begin
                fwd_en_q <= 1'b1;
              end
            end
          end else if (high_cnt_q >= HIGH_LIMIT) begin
            err_q     <= 1'b1;
            bit_cnt_q <= '0;
            fwd_en_q  <= 1'b0;
            low_cnt_q <= '0;
            state_q   <= SYNC;
          end else begin
            high_cnt_q <= high_cnt_d;
          end
        end

        default: state_q <= SYNC;
      endcase
    end
  end

  assign dout    = dout_q;
  assign grb     = grb_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign bit_cnt = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_pixel_rx.sv
`default_nettype none
// Bench for ws2812b_pixel_rx: expected latch/error events are queued as frames are driven and
// matched against DUT pulses; dout is compared every cycle against a delayed forward model.
module tb_ws2812b_pixel_rx;

  localparam int BT = 6;
  localparam int MH = 15;
  localparam int RC = 50;
  localparam int CW = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        dout;
  logic [23:0] grb;
  logic        valid;
  logic        err;
  logic [4:0]  bit_cnt;

  ws2812b_pixel_rx #(
    .BIT_THRESH  (BT),
    .MAX_HIGH    (MH),
    .RESET_CYCLES(RC),
    .CNT_W       (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .dout   (dout),
    .grb    (grb),
    .valid  (valid),
    .err    (err),
    .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [23:0] data;
    int          cyc;
  } ev_t;

  ev_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_fall = 0;
  logic        fwd_bit = 1'b0;
  logic [2:0]  fwd_pipe = 3'b000;
  logic [23:0] model_grb = 24'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) fwd_pipe <= 3'b000;
    else       fwd_pipe <= {fwd_pipe[1:0], fwd_bit};
  end

  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        chk("dout", {31'b0, dout}, {31'b0, fwd_pipe[2]});
        if (valid || err) begin
          chk("valid_err_excl", {31'b0, valid & err}, 32'd0);
          if (sb.size() == 0) begin
            chk("unexpected_event", {30'b0, valid, err}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk(e.is_err ? "err_evt" : "valid_evt", {31'b0, err}, {31'b0, e.is_err});
            chk("evt_cycle", cyc, e.cyc);
            chk("grb", {8'b0, grb}, {8'b0, e.data});
          end
        end
      end
    end
  end

  task automatic low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din     = 1'b0;
      fwd_bit = 1'b0;
    end
  endtask

  task automatic pulse(input int hi, input int lo, input logic fwd);
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      din     = 1'b1;
      fwd_bit = fwd;
    end
    for (int i = 0; i < lo; i++) begin
      @(negedge clk);
      din     = 1'b0;
      fwd_bit = 1'b0;
      if (i == 0) last_fall = cyc;
    end
  endtask

  task automatic send_word(input logic [23:0] w, input int nb, input logic fwd,
                           input int hi1, input int hi0, input int long_idx, input int long_lo);
    logic b;
    int   lo;
    for (int i = 0; i < nb; i++) begin
      b  = w[23-i];
      lo = b ? 4 : 10;
      if (i == long_idx) lo = long_lo;
      pulse(b ? hi1 : hi0, lo, fwd);
    end
  endtask

  task automatic send_std(input logic [23:0] w, input int nb, input logic fwd);
    send_word(w, nb, fwd, 10, 4, -1, 0);
  endtask

  // Gap events appear 52 counts after the din fall: 2 sync stages, 49 counted lows, 1 output reg.
  task automatic expect_latch(input logic [23:0] v);
    ev_t e;
    e.is_err = 1'b0;
    e.data   = v;
    e.cyc    = last_fall + 52;
    sb.push_back(e);
    model_grb = v;
  endtask

  task automatic expect_gap_err();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = model_grb;
    e.cyc    = last_fall + 52;
    sb.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    ev_t e;
    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {31'b0, dout}, 32'd0);
    chk("rst_grb", {8'b0, grb}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_bit_cnt", {27'b0, bit_cnt}, 32'd0);
    reset = 1'b0;
    low(60);

    // Single 24-bit frame
    send_std(24'hA53C0F, 24, 1'b0);
    chk("bit_cnt_full", {27'b0, bit_cnt}, 32'd24);
    expect_latch(24'hA53C0F);
    low(60);
    chk("bit_cnt_after_gap", {27'b0, bit_cnt}, 32'd0);

    // 48-bit frame: second half forwarded
    send_std(24'h123456, 24, 1'b0);
    send_std(24'hFEDCBA, 24, 1'b1);
    chk("bit_cnt_sat", {27'b0, bit_cnt}, 32'd24);
    expect_latch(24'h123456);
    low(60);

    // Short frame
    send_std(24'hABCDEF, 10, 1'b0);
    chk("bit_cnt_short", {27'b0, bit_cnt}, 32'd10);
    expect_gap_err();
    low(60);
    chk("bit_cnt_short_gap", {27'b0, bit_cnt}, 32'd0);

    // Over-long high pulse mid-frame
    send_std(24'h0F0F0F, 5, 1'b0);
    @(negedge clk);
    din     = 1'b1;
    fwd_bit = 1'b0;
    e.is_err = 1'b1;
    e.data   = model_grb;
    e.cyc    = cyc + 18;
    sb.push_back(e);
    pulse(19, 4, 1'b0);
    send_std(24'hFFFFFF, 8, 1'b0);
    chk("bit_cnt_in_sync", {27'b0, bit_cnt}, 32'd0);
    low(60);
    send_std(24'h5AC396, 24, 1'b0);
    expect_latch(24'h5AC396);
    low(60);

    // Boundary widths: 6 high -> 0, 7 high -> 1, 49-low inside the frame
    send_word(24'h96C35A, 24, 1'b0, 7, 6, 11, 49);
    chk("bit_cnt_49low", {27'b0, bit_cnt}, 32'd24);
    expect_latch(24'h96C35A);
    low(60);
    // Exactly 50 low is a gap, even with the next frame starting right after
    send_word(24'h5A5A5A, 12, 1'b0, 10, 4, 11, 50);
    expect_gap_err();
    send_std(24'hC0FFEE, 24, 1'b0);
    expect_latch(24'hC0FFEE);
    low(60);

    // Asynchronous reset during bit 12
    send_std(24'h13579B, 12, 1'b0);
    @(negedge clk);
    din = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_grb", {8'b0, grb}, 32'd0);
    chk("midrst_bit_cnt", {27'b0, bit_cnt}, 32'd0);
    chk("midrst_dout", {31'b0, dout}, 32'd0);
    chk("midrst_valid_err", {30'b0, valid, err}, 32'd0);
    model_grb = 24'h0;
    @(negedge clk);
    reset = 1'b0;
    pulse(7, 10, 1'b0);
    send_std(24'h13579B << 13, 11, 1'b0);
    chk("bit_cnt_after_rst", {27'b0, bit_cnt}, 32'd0);
    low(60);
    send_std(24'h2468AC, 24, 1'b0);
    expect_latch(24'h2468AC);
    low(60);

    low(20);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
